led_sched: RTL

LED_SCHED -- requirements
Module: led_sched

---
 rtl/led_sched_pkg.sv | 28 ++
 rtl/led_sched_tick.sv | 36 +++
 rtl/led_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED time-slice scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [1:0] RATE_SOLID = 2'd0;
  localparam logic [1:0] RATE_FAST  = 2'd1;
  localparam logic [1:0] RATE_MED   = 2'd2;
  localparam logic [1:0] RATE_SLOW  = 2'd3;

  // Each slower code samples the next higher bit of the tick phase.
  function automatic logic blink_level(input logic [2:0] phase, input logic [1:0] code);
    logic lvl;
    case (code)
      RATE_SOLID: lvl = 1'b1;
      RATE_FAST:  lvl = phase[0];
      RATE_MED:   lvl = phase[1];
      RATE_SLOW:  lvl = phase[2];
      default:    lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/led_sched_tick.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap at DIV-1 back to zero.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_sched.sv
// Round-robin LED time-slice scheduler: IDLE -> SERVE (slice) -> GAP (dark) -> arbitrate.
// Optional LED_SCHED_PRIO_EN: requester 0 pre-empts any other owner and wins the next arbitration.
module led_sched
  import led_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DIV         = 50000000,
  parameter int SLICE_TICKS = 8,
  parameter int GAP_TICKS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] rate,
  output logic [N_REQ-1:0]   grant,
  output logic               led,
  output logic               busy
);

  localparam int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAX_T = (SLICE_TICKS > GAP_TICKS) ? SLICE_TICKS : GAP_TICKS;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

  localparam logic [CW-1:0] SLICE_LOAD = CW'(SLICE_TICKS);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_TICKS);
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [OW-1:0] LAST_INIT  = OW'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      slice_q, slice_d;
  logic [2:0]         phase_q, phase_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               led_q, led_d;
  logic               busy_q;
  logic               tick_s;
  logic               preempt_s;
  logic               owner_req_s;
  logic [OW-1:0]      pick_s;
  logic [2*N_REQ-1:0] rate_sh_s;
  logic [1:0]         code_s;

  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] last);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && r[OW'(idx)]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
`ifdef LED_SCHED_PRIO_EN
    if (r[0]) begin
      pick = '0;
    end
`endif
    return pick;
  endfunction

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

`ifdef LED_SCHED_PRIO_EN
  assign preempt_s = req[0] && (owner_q != '0);
`else
  assign preempt_s = 1'b0;
`endif

  assign owner_req_s = req[owner_q];
  assign pick_s      = rr_pick(req, owner_q);

  // State machine; slice_q doubles as the gap tick counter while in GAP.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    slice_d = slice_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SERVE;
          owner_d = pick_s;
          slice_d = SLICE_LOAD;
          phase_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (!owner_req_s || preempt_s) begin
          state_d = GAP;
          slice_d = GAP_LOAD;
          phase_d = '0;
        end else if (tick_s) begin
          if (slice_q <= ONE) begin
            state_d = GAP;
            slice_d = GAP_LOAD;
            phase_d = '0;
          end else begin
            slice_d = slice_q - ONE;
            phase_d = phase_q + 3'd1;
          end
        end else begin
          state_d = SERVE;
        end
      end
      GAP: begin
        if ((GAP_TICKS == 0) || (tick_s && (slice_q <= ONE))) begin
          if (|req) begin
            state_d = SERVE;
            owner_d = pick_s;
            slice_d = SLICE_LOAD;
            phase_d = '0;
          end else begin
            state_d = IDLE;
            slice_d = '0;
          end
        end else if (tick_s) begin
          slice_d = slice_q - ONE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        slice_d = '0;
        phase_d = '0;
      end
    endcase
  end

  // Output values for the state being entered, so grant/led are registered.
  always_comb begin
    grant_d   = '0;
    led_d     = 1'b0;
    rate_sh_s = rate >> {owner_d, 1'b0};
    code_s    = rate_sh_s[1:0];
    if (state_d == SERVE) begin
      grant_d[owner_d] = 1'b1;
      led_d            = blink_level(phase_d, code_s);
    end else begin
      grant_d = '0;
      led_d   = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= LAST_INIT;
      slice_q <= '0;
      phase_q <= '0;
      grant_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      slice_q <= slice_d;
      phase_q <= phase_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign busy  = busy_q;

endmodule
